// File: rtl/fft_disp_pkg.sv
// Shared definitions for the spectrum display path: output magnitude width,
// saturation ceiling, framing FSM states and the default transform length.
package fft_disp_pkg;

  localparam int FFT_MAG_W = 9;
  localparam logic [FFT_MAG_W-1:0] FFT_MAG_MAX = 9'd511;
  localparam int DEFAULT_TRANSFORM_LEN = 1024;

  // IDLE waits for sop, PASS forwards bins, DROP discards a skipped frame
  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } frame_state_e;

endpackage

// File: rtl/fft_mag_approx.sv
// Three-stage |X| approximation: abs, max/min sort, alpha-max-plus-beta-min
// sum (mx + mn/4 + mn/8), then right shift and saturation to FFT_MAG_W bits.
// Valid, eop and len_err sidebands travel alongside the data.
module fft_mag_approx
  import fft_disp_pkg::*;
#(
  parameter int DIN_W     = 16,
  parameter int MAG_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIN_W-1:0]     re_i,
  input  logic [DIN_W-1:0]     im_i,
  input  logic                 valid_i,
  input  logic                 eop_i,
  input  logic                 lenErr_i,
  output logic [FFT_MAG_W-1:0] mag_o,
  output logic                 valid_o,
  output logic                 eop_o,
  output logic                 lenErr_o
);

  logic [DIN_W-1:0]     absRe_d, absIm_d;
  logic [DIN_W-1:0]     a_q, b_q;
  logic                 s1Valid_q, s1Eop_q, s1LenErr_q;
  logic [DIN_W-1:0]     mx_q, mn_q;
  logic                 s2Valid_q, s2Eop_q, s2LenErr_q;
  logic [DIN_W:0]       sum_d, shifted_d;
  logic [FFT_MAG_W-1:0] mag_d;
  logic [FFT_MAG_W-1:0] mag_q;
  logic                 s3Valid_q, s3Eop_q, s3LenErr_q;

  // Two's-complement absolute value; the most negative input becomes
  // 2^(DIN_W-1), which still fits as an unsigned DIN_W value
  always_comb begin
    absRe_d = re_i[DIN_W-1] ? (~re_i + 1'b1) : re_i;
    absIm_d = im_i[DIN_W-1] ? (~im_i + 1'b1) : im_i;
  end

  // Stage 1 register: magnitudes of both components plus sidebands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      s1Valid_q  <= 1'b0;
      s1Eop_q    <= 1'b0;
      s1LenErr_q <= 1'b0;
    end else begin
      a_q        <= absRe_d;
      b_q        <= absIm_d;
      s1Valid_q  <= valid_i;
      s1Eop_q    <= valid_i & eop_i;
      s1LenErr_q <= valid_i & lenErr_i;
    end
  end

  // Stage 2 register: sort into larger and smaller component
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx_q       <= '0;
      mn_q       <= '0;
      s2Valid_q  <= 1'b0;
      s2Eop_q    <= 1'b0;
      s2LenErr_q <= 1'b0;
    end else begin
      mx_q       <= (a_q >= b_q) ? a_q : b_q;
      mn_q       <= (a_q >= b_q) ? b_q : a_q;
      s2Valid_q  <= s1Valid_q;
      s2Eop_q    <= s1Eop_q;
      s2LenErr_q <= s1LenErr_q;
    end
  end

  // Sum is one bit wider than the input so mx + 3/8 mn never overflows;
  // anything above the display ceiling after shifting clips to full scale
  always_comb begin
    sum_d = {1'b0, mx_q} + (DIN_W+1)'(mn_q >> 2) + (DIN_W+1)'(mn_q >> 3);
    shifted_d = sum_d >> MAG_SHIFT;
    if (shifted_d > (DIN_W+1)'(FFT_MAG_MAX)) begin
      mag_d = FFT_MAG_MAX;
    end else begin
      mag_d = shifted_d[FFT_MAG_W-1:0];
    end
  end

  // Stage 3 register: saturated magnitude drives the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q      <= '0;
      s3Valid_q  <= 1'b0;
      s3Eop_q    <= 1'b0;
      s3LenErr_q <= 1'b0;
    end else begin
      mag_q      <= mag_d;
      s3Valid_q  <= s2Valid_q;
      s3Eop_q    <= s2Eop_q;
      s3LenErr_q <= s2LenErr_q;
    end
  end

  assign mag_o    = mag_q;
  assign valid_o  = s3Valid_q;
  assign eop_o    = s3Eop_q;
  assign lenErr_o = s3LenErr_q;

endmodule

// File: rtl/fft_mag_stream.sv
// FFT output to spectrum RAM producer: frames the complex stream, decimates
// frames via frame_skip, and forwards approximate bin magnitudes.
// Optional frame-length checking is enabled by defining FFT_MAG_LEN_CHECK_EN.
module fft_mag_stream
  import fft_disp_pkg::*;
#(
  parameter int DIN_W         = 16,
  parameter int TRANSFORM_LEN = DEFAULT_TRANSFORM_LEN,
  parameter int MAG_SHIFT     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] fft_in_re,
  input  logic [DIN_W-1:0] fft_in_im,
  input  logic             fft_in_valid,
  input  logic             fft_in_sop,
  input  logic             fft_in_eop,
  input  logic [3:0]       frame_skip,
  output logic [8:0]       fft_data,
  output logic             fft_valid,
  output logic             fft_eop,
  output logic [15:0]      frame_cnt,
  output logic             len_err
);

  localparam int BIN_W = (TRANSFORM_LEN > 1) ? $clog2(TRANSFORM_LEN) : 1;
`ifdef FFT_MAG_LEN_CHECK_EN
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(TRANSFORM_LEN - 1);
`endif

  frame_state_e   state_q, state_d;
  logic [3:0]     skipCnt_q, skipCnt_d;
  logic [BIN_W-1:0] binCnt_q, binCnt_d;
  logic [BIN_W-1:0] curBin;
  logic           passSample;
  logic           fwdValid, fwdEop, fwdLenErr;
  logic [15:0]    frameCnt_q;
  logic [FFT_MAG_W-1:0] magData;
  logic           magValid, magEop, magLenErr;

  // Framing decision for the current input sample. A sop always restarts
  // framing as if from IDLE, so the sample's bin index and pass/drop choice
  // come from the skip counter rather than the current state.
  always_comb begin
    state_d    = state_q;
    skipCnt_d  = skipCnt_q;
    binCnt_d   = binCnt_q;
    fwdValid   = 1'b0;
    fwdEop     = 1'b0;
    fwdLenErr  = 1'b0;
    curBin     = fft_in_sop ? '0 : binCnt_q;
    passSample = fft_in_sop ? (skipCnt_q == 4'd0) : (state_q == PASS);

    if (fft_in_valid) begin
      if (fft_in_sop) begin
        if (skipCnt_q == 4'd0) begin
          skipCnt_d = frame_skip;
        end else begin
          skipCnt_d = skipCnt_q - 4'd1;
        end
      end

      if (passSample) begin
        fwdValid = 1'b1;
        fwdEop   = fft_in_eop;
        if (fft_in_eop) begin
          state_d  = IDLE;
          binCnt_d = '0;
        end else begin
          state_d  = PASS;
          binCnt_d = curBin + 1'b1;
        end
`ifdef FFT_MAG_LEN_CHECK_EN
        if (curBin == LAST_BIN) begin
          if (!fft_in_eop) begin
            fwdEop    = 1'b1;
            fwdLenErr = 1'b1;
            state_d   = DROP;
            binCnt_d  = '0;
          end
        end else if (fft_in_eop) begin
          fwdLenErr = 1'b1;
        end
`endif
      end else if (fft_in_sop) begin
        state_d  = fft_in_eop ? IDLE : DROP;
        binCnt_d = '0;
      end else if ((state_q == DROP) && fft_in_eop) begin
        state_d = IDLE;
      end
    end
  end

  // Framing state, skip counter and bin counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      skipCnt_q <= 4'd0;
      binCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      skipCnt_q <= skipCnt_d;
      binCnt_q  <= binCnt_d;
    end
  end

  fft_mag_approx #(
    .DIN_W     (DIN_W),
    .MAG_SHIFT (MAG_SHIFT)
  ) uMagApprox (
    .clk      (clk),
    .rst_n    (rst_n),
    .re_i     (fft_in_re),
    .im_i     (fft_in_im),
    .valid_i  (fwdValid),
    .eop_i    (fwdEop),
    .lenErr_i (fwdLenErr),
    .mag_o    (magData),
    .valid_o  (magValid),
    .eop_o    (magEop),
    .lenErr_o (magLenErr)
  );

  // Count a frame once its last sample has actually left the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt_q <= 16'd0;
    end else if (magValid && magEop) begin
      frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign fft_data  = magData;
  assign fft_valid = magValid;
  assign fft_eop   = magValid & magEop;
  assign frame_cnt = frameCnt_q;
`ifdef FFT_MAG_LEN_CHECK_EN
  assign len_err   = magValid & magLenErr;
`else
  assign len_err   = 1'b0 & magLenErr;
`endif

endmodule

// File: tb/tb_fft_mag_stream.sv
// Directed bench for fft_mag_stream: magnitude values and latency, frame
// decimation, sop abort, mid-frame reset and (optionally) length checking.
module tb_fft_mag_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] fft_in_re, fft_in_im;
  logic        fft_in_valid, fft_in_sop, fft_in_eop;
  logic [3:0]  frameSkip;

  logic [8:0]  fft_data, fftData0;
  logic        fft_valid, fftValid0;
  logic        fft_eop, fftEop0;
  logic [15:0] frame_cnt, frameCnt0;
  logic        len_err, lenErr0;

  int vectorCount = 0;
  int missCount   = 0;

  int validCount  = 0;
  int eopCount    = 0;
  int lenErrCount = 0;
  int lenErrAtEop = 0;
  int runLen      = 0;
  int lastEopData = 0;
  int frameLen [16];

  int tRe  [5] = '{-200, 300, -32768, 640, 0};
  int tIm  [5] = '{100, -400, 0, 0, 0};
  int exp0 [5] = '{237, 511, 511, 511, 0};
  int exp6 [5] = '{3, 8, 511, 10, 0};

  fft_mag_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fft_in_re    (fft_in_re),
    .fft_in_im    (fft_in_im),
    .fft_in_valid (fft_in_valid),
    .fft_in_sop   (fft_in_sop),
    .fft_in_eop   (fft_in_eop),
    .frame_skip   (frameSkip),
    .fft_data     (fft_data),
    .fft_valid    (fft_valid),
    .fft_eop      (fft_eop),
    .frame_cnt    (frame_cnt),
    .len_err      (len_err)
  );

  fft_mag_stream #(.MAG_SHIFT(0)) dutShift0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .fft_in_re    (fft_in_re),
    .fft_in_im    (fft_in_im),
    .fft_in_valid (fft_in_valid),
    .fft_in_sop   (fft_in_sop),
    .fft_in_eop   (fft_in_eop),
    .frame_skip   (frameSkip),
    .fft_data     (fftData0),
    .fft_valid    (fftValid0),
    .fft_eop      (fftEop0),
    .frame_cnt    (frameCnt0),
    .len_err      (lenErr0)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor on the falling edge: tallies valids, eops, len_err pulses
  // and the number of valid bins delivered per forwarded frame
  always @(negedge clk) begin
    if (!rst_n) begin
      runLen <= 0;
    end else begin
      if (fft_valid) begin
        validCount <= validCount + 1;
      end
      if (fft_eop) begin
        eopCount             <= eopCount + 1;
        frameLen[eopCount % 16] <= runLen + (fft_valid ? 1 : 0);
        lastEopData          <= int'(fft_data);
        runLen               <= 0;
        if (len_err) begin
          lenErrAtEop <= lenErrAtEop + 1;
        end
      end else if (fft_valid) begin
        runLen <= runLen + 1;
      end
      if (len_err) begin
        lenErrCount <= lenErrCount + 1;
      end
    end
  end

  // Single comparison point; every check counts here
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one input cycle on the falling edge
  task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im,
                               input logic v, input logic s, input logic e);
    @(negedge clk);
    fft_in_re    = re;
    fft_in_im    = im;
    fft_in_valid = v;
    fft_in_sop   = s;
    fft_in_eop   = e;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // A frame whose bin i carries (i, -i); eopAt < 0 means no eop is sent
  task automatic sendFrame(input int nSamples, input int eopAt);
    for (int i = 0; i < nSamples; i++) begin
      applyStimulus(16'(i), 16'(-i), 1'b1, i == 0, i == eopAt);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n        = 1'b0;
    fft_in_valid = 1'b0;
    fft_in_sop   = 1'b0;
    fft_in_eop   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v0, e0, l0, la0;
    rst_n        = 1'b0;
    fft_in_re    = '0;
    fft_in_im    = '0;
    fft_in_valid = 1'b0;
    fft_in_sop   = 1'b0;
    fft_in_eop   = 1'b0;
    frameSkip    = 4'd0;

    // Reset state
    @(negedge clk);
    checkOutput("rst data", int'(fft_data), 0);
    checkOutput("rst valid", int'(fft_valid), 0);
    checkOutput("rst eop", int'(fft_eop), 0);
    checkOutput("rst frame_cnt", int'(frame_cnt), 0);
    checkOutput("rst len_err", int'(len_err), 0);
    checkOutput("rst valid s0", int'(fftValid0), 0);
    rst_n = 1'b1;

    // Magnitude values and 3-cycle latency, both shift settings
    $display("[TB] magnitude vectors");
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        applyStimulus(16'(tRe[i]), 16'(tIm[i]), 1'b1, i == 0, i == 4);
      end else begin
        applyStimulus(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      end
      if (i == 2) begin
        checkOutput("latency valid", int'(fft_valid), 0);
      end
      if (i >= 3) begin
        checkOutput($sformatf("mag%0d valid", i-3), int'(fft_valid), 1);
        checkOutput($sformatf("mag%0d sh6", i-3), int'(fft_data), exp6[i-3]);
        checkOutput($sformatf("mag%0d valid sh0", i-3), int'(fftValid0), 1);
        checkOutput($sformatf("mag%0d sh0", i-3), int'(fftData0), exp0[i-3]);
        checkOutput($sformatf("mag%0d eop", i-3), int'(fft_eop), (i == 7) ? 1 : 0);
        checkOutput($sformatf("mag%0d eop sh0", i-3), int'(fftEop0), (i == 7) ? 1 : 0);
      end
    end
    idleCycles(1);
    checkOutput("mag frame_cnt", int'(frame_cnt), 1);
    checkOutput("mag frame_cnt sh0", int'(frameCnt0), 1);
    checkOutput("mag after valid", int'(fft_valid), 0);

    // Frame decimation: seven back-to-back frames with frame_skip=2
    $display("[TB] decimation frames");
    resetDut();
    checkOutput("reset frame_cnt", int'(frame_cnt), 0);
    frameSkip = 4'd2;
    v0 = validCount;
    e0 = eopCount;
    for (int f = 0; f < 7; f++) begin
      sendFrame(1024, 1023);
    end
    idleCycles(4);
    checkOutput("skip valids", validCount - v0, 3072);
    checkOutput("skip eops", eopCount - e0, 3);
    for (int f = 0; f < 3; f++) begin
      checkOutput($sformatf("skip len%0d", f), frameLen[(e0 + f) % 16], 1024);
    end
    checkOutput("skip frame_cnt", int'(frame_cnt), 3);
    checkOutput("skip last data", lastEopData, 21);

    // sop at sample 500 abandons the frame without an eop
    $display("[TB] sop abort");
    resetDut();
    frameSkip = 4'd0;
    v0 = validCount;
    e0 = eopCount;
    sendFrame(500, -1);
    sendFrame(1024, 1023);
    idleCycles(4);
    checkOutput("abort eops", eopCount - e0, 1);
    checkOutput("abort valids", validCount - v0, 1524);
    checkOutput("abort len", frameLen[e0 % 16], 1524);
    checkOutput("abort frame_cnt", int'(frame_cnt), 1);

    // Reset asserted mid-frame at sample 300
    $display("[TB] mid-frame reset");
    sendFrame(300, -1);
    checkOutput("pre-rst valid", int'(fft_valid), 1);
    @(negedge clk);
    rst_n        = 1'b0;
    fft_in_valid = 1'b0;
    fft_in_sop   = 1'b0;
    #1;
    checkOutput("in-rst valid", int'(fft_valid), 0);
    checkOutput("in-rst frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = validCount;
    for (int i = 300; i < 400; i++) begin
      applyStimulus(16'(i), 16'(i), 1'b1, 1'b0, 1'b0);
    end
    idleCycles(4);
    checkOutput("post-rst no output", validCount - v0, 0);
    e0 = eopCount;
    sendFrame(1024, 1023);
    idleCycles(4);
    checkOutput("post-rst eops", eopCount - e0, 1);
    checkOutput("post-rst len", frameLen[e0 % 16], 1024);
    checkOutput("post-rst frame_cnt", int'(frame_cnt), 1);

`ifdef FFT_MAG_LEN_CHECK_EN
    // Early eop and missing eop both flag len_err with the eop
    $display("[TB] length checking");
    resetDut();
    frameSkip = 4'd0;
    e0  = eopCount;
    l0  = lenErrCount;
    la0 = lenErrAtEop;
    sendFrame(512, 511);
    idleCycles(4);
    checkOutput("early eops", eopCount - e0, 1);
    checkOutput("early len", frameLen[e0 % 16], 512);
    checkOutput("early len_err", lenErrCount - l0, 1);
    checkOutput("early len_err at eop", lenErrAtEop - la0, 1);
    v0  = validCount;
    e0  = eopCount;
    l0  = lenErrCount;
    la0 = lenErrAtEop;
    sendFrame(1030, -1);
    idleCycles(4);
    checkOutput("forced valids", validCount - v0, 1024);
    checkOutput("forced eops", eopCount - e0, 1);
    checkOutput("forced len", frameLen[e0 % 16], 1024);
    checkOutput("forced len_err", lenErrCount - l0, 1);
    checkOutput("forced len_err at eop", lenErrAtEop - la0, 1);
    e0 = eopCount;
    l0 = lenErrCount;
    sendFrame(1024, 1023);
    idleCycles(4);
    checkOutput("good eops", eopCount - e0, 1);
    checkOutput("good len_err", lenErrCount - l0, 0);
`else
    checkOutput("len_err never", lenErrCount, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/fft_mag_stream.md
Name: fft_mag_stream

Overview:
Producer end of the spectrum display RAM write interface. Takes the streaming complex output of the FFT core (re/im with sop/eop) and approximates |X| per bin. It scales and saturates the result to 9 bits, then emits fft_data/fft_valid/fft_eop to the spectrum RAM controller. Frame decimation keeps the display refresh below the FFT frame rate.

Parameters:
DIN_W, 16, width of signed re/im input samples
TRANSFORM_LEN, 1024, samples per FFT frame
MAG_SHIFT, 6, right shift applied to approximate magnitude before saturation

Ports:
clk  in  1  system clock (single clock domain)
rst_n  in  1  asynchronous active-low reset
fft_in_re  in  DIN_W  signed real part
fft_in_im  in  DIN_W  signed imaginary part
fft_in_valid  in  1  input sample valid
fft_in_sop  in  1  first sample of frame (qualified by valid)
fft_in_eop  in  1  last sample of frame (qualified by valid)
frame_skip  in  4  drop N frames after each forwarded frame; sampled at sop
fft_data  out  9  saturated magnitude
fft_valid  out  1  fft_data valid
fft_eop  out  1  last forwarded sample, coincident with its fft_valid
frame_cnt  out  16  forwarded-frame counter, wraps at 2^16
len_err  out  1  one-cycle pulse on frame-length violation (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): fft_data=0, fft_valid=0, fft_eop=0, frame_cnt=0, len_err=0, state=IDLE, skip_cnt=0, bin_cnt=0. Pipeline valids are cleared, so no partial output follows reset release.
- Magnitude pipeline, 3 cycles input-to-output, accepts one sample per cycle, no backpressure:
  - S1: a=|re|, b=|im|, each DIN_W unsigned. -2^(DIN_W-1) maps to 2^(DIN_W-1), which fits.
  - S2: mx=max(a,b), mn=min(a,b).
  - S3: m = mx + (mn>>2) + (mn>>3), width DIN_W+1. Then m>>MAG_SHIFT, saturated to 511.
- fft_valid/fft_eop are the S3-delayed copies of the gated input valid/eop. fft_eop is high only together with fft_valid.
- Framing FSM, evaluated on input-side samples with fft_in_valid=1:
  - IDLE: samples without sop are discarded. On sop: if skip_cnt==0, go to PASS and load skip_cnt=frame_skip; else go to DROP and decrement skip_cnt.
  - PASS: samples are forwarded into the pipeline and bin_cnt increments. On eop, the sample is forwarded with eop, frame_cnt increments when it leaves S3, and the FSM returns to IDLE.
  - DROP: samples are discarded. On eop, return to IDLE.
- sop and eop on the same sample: treated as a one-sample frame (enter and exit).
- sop while in PASS or DROP: the current frame is abandoned without emitting fft_eop, and the sample is processed as a new sop from IDLE. Downstream overwrites the stale addresses.
- fft_in_valid=0: no state change. Gaps within a frame are allowed.
- frame_skip=0: every frame is forwarded.

Optional Feature:
Macro FFT_MAG_LEN_CHECK_EN.
- Defined, in PASS:
  - eop on a sample other than bin_cnt==TRANSFORM_LEN-1: fft_eop is forwarded, and len_err pulses 1 cycle aligned with that fft_eop.
  - bin_cnt reaching TRANSFORM_LEN-1 without eop: eop is forced on that sample, len_err pulses, and the FSM goes to DROP until the next eop or sop.
- Undefined: input eop is passed unchecked, no forced eop, and len_err is tied to 0.

Decomposition:
- Package fft_disp_pkg:
  - FFT_MAG_W=9, FFT_MAG_MAX=9'd511
  - frame state enum {IDLE, PASS, DROP}
  - default TRANSFORM_LEN.
- One sub-module, fft_mag_approx: the 3-stage abs/max-min/sum/saturate pipeline, carrying valid and eop sidebands.

Test Plan:
- MAG_SHIFT=0, PASS frame; (re,im)=(-200,100) -> fft_data=237. (300,-400) -> 512, saturated to 511. Each appears 3 cycles after input.
- Default MAG_SHIFT=6; re=-32768, im=0 -> 511. re=640, im=0 -> 10. re=0, im=0 -> 0.
- 1024-sample frames back-to-back, frame_skip=2 -> frames 0,3,6 forwarded, each with exactly 1024 fft_valid and a single fft_eop on the last. frame_cnt ends at 3 after 7 input frames.
- sop at sample 500 of a PASS frame -> no fft_eop for the aborted frame. The new frame follows the skip rule; with frame_skip=0 it is forwarded complete.
- rst_n asserted mid-frame at sample 300 -> fft_valid=0 within the reset cycle. After release, samples before the next sop produce no output.
- With FFT_MAG_LEN_CHECK_EN: eop at sample 511 -> fft_eop plus len_err pulse. No eop through sample 1023 -> forced fft_eop at sample 1023, len_err=1, and following samples are dropped until sop.
